multicycle_ctrl: RTL and testbench

Multi-cycle control FSM for the Fibonacci microprocessor. It sequences the fetch, decode, execute, memory and writeback steps of each instruction. It drives the PC/IR write enables, the memory request handshake, the register-file write enable and the 2-bit writeback-source select that steers the ALU result, memory read data or PC+4 into the register file. It sits between the instruction register / ALU flags and the datapath muxes and enables.

---
 rtl/ctrl_pkg.sv | 42 ++++
 rtl/opcode_decoder.sv | 25 ++
 rtl/multicycle_ctrl.sv | 142 ++++++++++++++
 tb/tb_multicycle_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control FSM:
// state / opcode-class encodings, opcode values and datapath mux selects.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_OP     = 3'd0,
        CLS_OP_IMM = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JAL    = 3'd5,
        CLS_SYSTEM = 3'd6
    } op_class_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [1:0] ALU_TO_PRF         = 2'd0;
    localparam logic [1:0] DATA_OUT_TO_PRF    = 2'd1;
    localparam logic [1:0] INSTRUCTION_TO_PRF = 2'd2;

    localparam logic PC_PLUS4    = 1'b0;
    localparam logic PC_PLUS_IMM = 1'b1;
    localparam logic ADDR_PC     = 1'b0;
    localparam logic ADDR_ALU    = 1'b1;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier; unknown opcodes report legal=0 with class OP.
module opcode_decoder
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class,
    output logic       legal
);

    always_comb begin
        op_class = CLS_OP;
        legal    = 1'b1;
        case (opcode)
            OPC_OP:     op_class = CLS_OP;
            OPC_OP_IMM: op_class = CLS_OP_IMM;
            OPC_LOAD:   op_class = CLS_LOAD;
            OPC_STORE:  op_class = CLS_STORE;
            OPC_BRANCH: op_class = CLS_BRANCH;
            OPC_JAL:    op_class = CLS_JAL;
            OPC_SYSTEM: op_class = CLS_SYSTEM;
            default:    legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: fetch / decode / execute / memory / writeback
// sequencing with retired-instruction counter and sticky halt flags.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [6:0]       opcode,
    input  logic             branch_cond,
    input  logic             mem_ready,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             alu_src_b,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       state_o
);

    state_t    state, state_next;
    op_class_t op_class, dec_class;
    logic      dec_legal;
    logic      retire;

    opcode_decoder u_dec (
        .opcode   (opcode),
        .op_class (dec_class),
        .legal    (dec_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_class    <= CLS_OP;
            halted      <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                op_class <= dec_class;
                if (!dec_legal)
                    illegal <= 1'b1;
            end
            if (state_next == S_HALT)
                halted <= 1'b1;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_next   = state;
        retire       = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        alu_src_b    = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = ADDR_PC;
        rf_we        = 1'b0;
        wb_sel       = ALU_TO_PRF;
        case (state)
            S_IDLE: begin
                if (start)
                    state_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req      = 1'b1;
                mem_addr_sel = ADDR_PC;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!dec_legal || dec_class == CLS_SYSTEM)
                    state_next = S_HALT;
                else
                    state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                alu_src_b = (op_class == CLS_OP_IMM) || (op_class == CLS_LOAD) ||
                            (op_class == CLS_STORE);
                case (op_class)
                    CLS_LOAD, CLS_STORE: state_next = S_MEMORY;
                    CLS_BRANCH: begin
                        pc_we      = 1'b1;
                        pc_sel     = branch_cond;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end
                    default: state_next = S_WRITEBACK;
                endcase
            end
            S_MEMORY: begin
                // Request attributes depend only on the latched class, so they
                // stay constant for the whole handshake.
                mem_req      = 1'b1;
                mem_addr_sel = ADDR_ALU;
                mem_we       = (op_class == CLS_STORE);
                if (mem_ready) begin
                    if (op_class == CLS_STORE) begin
                        pc_we      = 1'b1;
                        pc_sel     = PC_PLUS4;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                rf_we = 1'b1;
                case (op_class)
                    CLS_LOAD: wb_sel = DATA_OUT_TO_PRF;
                    CLS_JAL:  wb_sel = INSTRUCTION_TO_PRF;
                    default:  wb_sel = ALU_TO_PRF;
                endcase
                pc_we      = 1'b1;
                pc_sel     = (op_class == CLS_JAL) ? PC_PLUS_IMM : PC_PLUS4;
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_IDLE;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized directed bench for multicycle_ctrl; expected per-cycle traces
// are built from the instruction class and handshake waits.
module tb_multicycle_ctrl;

    localparam int CNT_W = 2;

    localparam logic [6:0] O_OP = 7'b0110011, O_IMM = 7'b0010011, O_LD = 7'b0000011,
                           O_ST = 7'b0100011, O_BR = 7'b1100011, O_JAL = 7'b1101111,
                           O_SYS = 7'b1110011;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [6:0]       opcode = 7'd0;
    logic             branch_cond = 1'b0;
    logic             mem_ready = 1'b0;
    logic             ir_we, pc_we, pc_sel, alu_src_b, mem_req, mem_we, mem_addr_sel, rf_we;
    logic [1:0]       wb_sel;
    logic             halted, illegal;
    logic [CNT_W-1:0] instr_count;
    logic [2:0]       state_o;

    int checks = 0;
    int errors = 0;
    int model_cnt = 0;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
        .branch_cond(branch_cond), .mem_ready(mem_ready), .ir_we(ir_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .alu_src_b(alu_src_b), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .rf_we(rf_we), .wb_sel(wb_sel),
        .halted(halted), .illegal(illegal), .instr_count(instr_count), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit legal_op(input logic [6:0] op);
        return op inside {O_OP, O_IMM, O_LD, O_ST, O_BR, O_JAL, O_SYS};
    endfunction

    // {ir_we,pc_we,alu_src_b,mem_req,mem_we,mem_addr_sel,rf_we,wb_sel}
    function automatic logic [8:0] exp_ctrl(input int s, input logic [6:0] op, input bit rdy);
        logic [8:0] v;
        logic       pw;
        v  = '0;
        pw = (s == 3 && op == O_BR) || (s == 4 && rdy && op == O_ST) || (s == 5);
        v[8] = (s == 1) && rdy;
        v[7] = pw;
        v[6] = (s == 3) && (op inside {O_IMM, O_LD, O_ST});
        v[5] = (s == 1) || (s == 4);
        v[4] = (s == 4) && (op == O_ST);
        v[3] = (s == 4);
        v[2] = (s == 5);
        if (s == 5) v[1:0] = (op == O_LD) ? 2'd1 : (op == O_JAL) ? 2'd2 : 2'd0;
        return v;
    endfunction

    function automatic logic [8:0] ctrl_now();
        return {ir_we, pc_we, alu_src_b, mem_req, mem_we, mem_addr_sel, rf_we, wb_sel};
    endfunction

    // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 after the
    // instruction completes (back in FETCH, or in HALT).
    task automatic run_instr(input logic [6:0] op, input logic bc, input int fw, input int mw);
        int st[$];
        bit rdy[$];
        bit stops;
        stops = !legal_op(op) || op == O_SYS;
        for (int i = 0; i <= fw; i++) begin st.push_back(1); rdy.push_back(i == fw); end
        st.push_back(2); rdy.push_back($urandom_range(1, 0) == 1);
        if (!stops) begin
            st.push_back(3); rdy.push_back($urandom_range(1, 0) == 1);
            if (op == O_LD || op == O_ST)
                for (int i = 0; i <= mw; i++) begin st.push_back(4); rdy.push_back(i == mw); end
            if (op inside {O_OP, O_IMM, O_JAL, O_LD}) begin
                st.push_back(5); rdy.push_back($urandom_range(1, 0) == 1);
            end
        end
        for (int i = 0; i < st.size(); i++) begin
            opcode      = op;
            branch_cond = bc;
            mem_ready   = rdy[i];
            #1;
            chk($sformatf("state[%0d] op=%b", i, op), 32'(state_o), 32'(st[i]));
            chk($sformatf("ctrl[%0d] op=%b", i, op), 32'(ctrl_now()), 32'(exp_ctrl(st[i], op, rdy[i])));
            if (exp_ctrl(st[i], op, rdy[i])[7])
                chk($sformatf("pc_sel[%0d] op=%b", i, op), 32'(pc_sel),
                    32'((st[i] == 3) ? bc : (st[i] == 5 && op == O_JAL)));
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        if (stops) begin
            chk("halt_state", 32'(state_o), 32'd6);
            chk("halted", 32'(halted), 32'd1);
            chk("illegal", 32'(illegal), 32'(!legal_op(op)));
        end else begin
            model_cnt = (model_cnt + 1) % (1 << CNT_W);
            chk("back_to_fetch", 32'(state_o), 32'd1);
            chk("instr_count", 32'(instr_count), 32'(model_cnt));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        model_cnt = 0;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_ctrl", 32'(ctrl_now()), 32'd0);
        chk("rst_flags", 32'({halted, illegal}), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic kick();
        start = 1'b1;
        #1;
        chk("idle_before_start", 32'(state_o), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    logic [6:0] pool [6] = '{O_OP, O_IMM, O_LD, O_ST, O_BR, O_JAL};

    initial begin
        do_reset();
        // Idle with start low stays idle.
        @(posedge clk); #1;
        chk("idle_hold", 32'(state_o), 32'd0);
        kick();
        run_instr(O_IMM, 1'b0, 0, 0);
        run_instr(O_LD, 1'b0, 0, 3);
        run_instr(O_BR, 1'b1, 0, 0);
        run_instr(O_BR, 1'b0, 1, 0);
        run_instr(O_JAL, 1'b0, 0, 0);
        run_instr(O_ST, 1'b0, 2, 1);
        run_instr(O_OP, 1'b1, 0, 0);
        for (int n = 0; n < 40; n++)
            run_instr(pool[$urandom_range(5, 0)], 1'($urandom_range(1, 0)),
                      int'($urandom_range(3, 0)), int'($urandom_range(3, 0)));

        // Reset landing in the middle of a data request.
        opcode    = O_LD;
        mem_ready = 1'b1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_mem_state", 32'(state_o), 32'd4);
        chk("mid_mem_req", 32'(mem_req), 32'd1);
        #2;
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("async_rst_state", 32'(state_o), 32'd0);
        chk("async_rst_ctrl", 32'(ctrl_now()), 32'd0);
        chk("async_rst_count", 32'(instr_count), 32'd0);
        mem_ready = 1'b0;
        do_reset();

        // Five retirements through a 2-bit counter wrap to 1.
        kick();
        for (int n = 0; n < 5; n++)
            run_instr(pool[$urandom_range(5, 0)], 1'($urandom_range(1, 0)),
                      int'($urandom_range(2, 0)), int'($urandom_range(2, 0)));
        chk("wrap5", 32'(instr_count), 32'd1);

        run_instr(7'b0000000, 1'b0, 0, 0);
        start = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            chk("illegal_absorb", 32'({state_o, halted, illegal}), 32'({3'd6, 1'b1, 1'b1}));
        end
        start = 1'b0;

        do_reset();
        kick();
        run_instr(O_IMM, 1'b0, 0, 0);
        run_instr(O_SYS, 1'b0, 1, 0);
        start = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            chk("system_absorb", 32'({state_o, halted, illegal, instr_count}),
                32'({3'd6, 1'b1, 1'b0, 2'd1}));
        end
        start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
